// File: rtl/read_wrr_scheduler_vdma.sv
// Weighted round-robin scheduler for the shared VDMA read command path (8 channels).
// Optional watchdog enabled by defining VDMA_RD_SCHED_TIMEOUT_EN.
module read_wrr_scheduler_vdma #(
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      sys_clk_i,
  input  logic                      reset_i,
  input  logic [7:0]                req_i,
  input  logic [8*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                      ack_i,
  input  logic                      done_i,
  output logic                      req_o,
  output logic [2:0]                mux_sel_o,
  output logic [7:0]                grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_ptr;
  logic [2:0]              r_sel;
  logic [WEIGHT_WIDTH-1:0] r_cnt;
  logic [WEIGHT_WIDTH-1:0] r_eff_weight;
  logic [7:0]              r_grant;
  logic                    r_req;
  logic                    r_timeout;

  logic [WEIGHT_WIDTH-1:0] w_weights [8];
  logic                    w_found;
  logic [2:0]              w_idx;
  logic [WEIGHT_WIDTH:0]   w_n;
  logic                    w_rotate;
  logic                    w_complete;
  logic                    w_expire;

  // Cyclic search starting at ptr; returns {found, index}.
  function automatic logic [3:0] arb_search(input logic [7:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_weights[i] = weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  always_comb begin
    {w_found, w_idx} = arb_search(req_i, r_ptr);
  end

  always_comb begin
    w_complete = ((r_state == S_REQ) && ack_i && done_i) ||
                 ((r_state == S_WAIT) && done_i);
    // Consecutive-burst count only continues while the same channel keeps winning.
    w_n        = (r_sel == r_ptr) ? ({1'b0, r_cnt} + 1'b1) : (WEIGHT_WIDTH+1)'(1);
    w_rotate   = (w_n >= {1'b0, r_eff_weight});
  end

`ifdef VDMA_RD_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ARB) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    w_expire = ((r_state == S_REQ) || (r_state == S_WAIT)) && !w_complete &&
               (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  end
`else
  // Without the watchdog the scheduler never expires.
  always_comb begin
    w_expire = (TIMEOUT_CYCLES < 0);
  end
`endif

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (|req_i) w_next = S_ARB;
      S_ARB:  w_next = w_found ? S_REQ : S_IDLE;
      S_REQ: begin
        if (w_complete || w_expire) w_next = S_IDLE;
        else if (ack_i)             w_next = S_WAIT;
      end
      S_WAIT: if (w_complete || w_expire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (r_state != S_IDLE);
    req_o     = r_req;
    mux_sel_o = r_sel;
    grant_o   = r_grant;
    timeout_o = r_timeout;
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_req     <= 1'b0;
      r_sel     <= 3'd0;
      r_grant   <= 8'd0;
      r_ptr     <= 3'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      r_req     <= (r_state == S_REQ) && !ack_i && !w_expire;
      if ((r_state == S_ARB) && w_found) begin
        r_sel   <= w_idx;
        r_grant <= 8'h01 << w_idx;
      end
      if (w_complete) begin
        r_grant <= 8'd0;
        if (w_rotate) begin
          r_ptr <= r_sel + 3'd1;
          r_cnt <= '0;
        end else begin
          r_ptr <= r_sel;
          r_cnt <= w_n[WEIGHT_WIDTH-1:0];
        end
      end else if (w_expire) begin
        r_grant <= 8'd0;
        r_ptr   <= r_sel + 3'd1;
        r_cnt   <= '0;
      end
    end
  end

  // Weight is a snapshot taken at arbitration; later weight_i changes wait for the next ARB.
  always_ff @(posedge sys_clk_i) begin
    if ((r_state == S_ARB) && w_found) r_eff_weight <= eff_weight(w_weights[w_idx]);
  end

endmodule

// File: tb/tb_read_wrr_scheduler_vdma.sv
// Directed self-checking bench for read_wrr_scheduler_vdma (watchdog case under VDMA_RD_SCHED_TIMEOUT_EN).
module tb_read_wrr_scheduler_vdma;

`ifdef VDMA_RD_SCHED_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 4096;
`endif

  logic        sys_clk_i;
  logic        reset_i;
  logic [7:0]  req_i;
  logic [31:0] weight_i;
  logic        ack_i;
  logic        done_i;
  logic        req_o;
  logic [2:0]  mux_sel_o;
  logic [7:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  int checks   = 0;
  int failures = 0;

  read_wrr_scheduler_vdma #(
    .WEIGHT_WIDTH  (4),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .sys_clk_i(sys_clk_i),
    .reset_i  (reset_i),
    .req_i    (req_i),
    .weight_i (weight_i),
    .ack_i    (ack_i),
    .done_i   (done_i),
    .req_o    (req_o),
    .mux_sel_o(mux_sel_o),
    .grant_o  (grant_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a command, check the owner, then finish the burst.
  task automatic serve(input string tag, input int exp_ch, input bit split);
    int n;
    n = 0;
    while (req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(req_o), 32'd1);
    chk({tag, "_sel"}, 32'(mux_sel_o), 32'(exp_ch));
    chk({tag, "_gnt"}, 32'(grant_o), 32'(8'h01 << exp_ch));
    if (split) begin
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
      chk({tag, "_wait_req"}, 32'(req_o), 32'd0);
      chk({tag, "_wait_busy"}, 32'(busy_o), 32'd1);
      done_i = 1'b1;
      step();
      done_i = 1'b0;
    end else begin
      ack_i  = 1'b1;
      done_i = 1'b1;
      step();
      ack_i  = 1'b0;
      done_i = 1'b0;
    end
    chk({tag, "_end_gnt"}, 32'(grant_o), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    reset_i  = 1'b1;
    req_i    = 8'h00;
    weight_i = 32'h1111_1111;
    ack_i    = 1'b0;
    done_i   = 1'b0;
    step();
    step();
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_sel", 32'(mux_sel_o), 32'd0);
    chk("rst_gnt", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tmo", 32'(timeout_o), 32'd0);

    // Single requester on channel 3 with latency checks.
    reset_i = 1'b0;
    req_i   = 8'h08;
    step();
    chk("single_arb_busy", 32'(busy_o), 32'd1);
    chk("single_arb_req", 32'(req_o), 32'd0);
    chk("single_arb_gnt", 32'(grant_o), 32'd0);
    step();
    chk("single_req0", 32'(req_o), 32'd0);
    chk("single_gnt", 32'(grant_o), 32'h08);
    chk("single_sel", 32'(mux_sel_o), 32'd3);
    step();
    chk("single_req1", 32'(req_o), 32'd1);
    serve("single", 3, 1'b1);
    req_i = 8'h18;
    serve("after3_a", 4, 1'b0);
    serve("after3_b", 3, 1'b0);

    // Reset while waiting for done: outputs clear without a clock edge.
    req_i = 8'h02;
    serve_to_wait();
    #1;
    reset_i = 1'b1;
    #1;
    chk("async_req", 32'(req_o), 32'd0);
    chk("async_sel", 32'(mux_sel_o), 32'd0);
    chk("async_gnt", 32'(grant_o), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd0);
    chk("async_tmo", 32'(timeout_o), 32'd0);
    req_i = 8'hFF;
    step();
    reset_i = 1'b0;

    // All eight requesting, weight 1: plain rotation starting at ch0.
    for (int i = 0; i < 9; i++) serve($sformatf("rr%0d", i), i % 8, 1'b0);

    // ch0 weight 3, ch1 weight 1; pointer is at 1 after the rotation above.
    req_i    = 8'h03;
    weight_i = 32'h1111_1113;
    serve("w_a", 1, 1'b0);
    serve("w_b", 0, 1'b0);
    serve("w_c", 0, 1'b0);
    serve("w_d", 0, 1'b0);
    serve("w_e", 1, 1'b0);
    serve("w_f", 0, 1'b1);
    serve("w_g", 0, 1'b0);
    serve("w_h", 0, 1'b0);
    serve("w_i", 1, 1'b0);

    // Zero weight on ch2 behaves as weight 1; pointer moves on to 3.
    weight_i = 32'h1111_1011;
    req_i    = 8'h04;
    serve("z_a", 2, 1'b0);
    serve("z_b", 2, 1'b0);
    req_i = 8'h0C;
    step();
    chk("z_next_arb_req", 32'(req_o), 32'd0);
    step();
    chk("z_next_req0", 32'(req_o), 32'd0);
    step();
    chk("z_next_req1", 32'(req_o), 32'd1);
    chk("z_next_sel", 32'(mux_sel_o), 32'd3);
    ack_i  = 1'b1;
    done_i = 1'b1;
    step();
    ack_i  = 1'b0;
    done_i = 1'b0;
    chk("z_next_end_busy", 32'(busy_o), 32'd0);
    req_i = 8'h00;

`ifdef VDMA_RD_SCHED_TIMEOUT_EN
    // ch5 acked but never done: watchdog fires 16 edges after REQ entry.
    req_i = 8'h20;
    step();
    step();
    chk("t_entry_gnt", 32'(grant_o), 32'h20);
    step();
    chk("t_req", 32'(req_o), 32'd1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("t_pre", 32'(timeout_o), 32'd0);
    chk("t_pre_busy", 32'(busy_o), 32'd1);
    step();
    chk("t_pulse", 32'(timeout_o), 32'd1);
    chk("t_gnt", 32'(grant_o), 32'd0);
    chk("t_reqo", 32'(req_o), 32'd0);
    chk("t_busy", 32'(busy_o), 32'd0);
    req_i = 8'h60;
    step();
    chk("t_pulse_end", 32'(timeout_o), 32'd0);
    serve("t_next", 6, 1'b0);
    req_i = 8'h00;
`else
    for (int i = 0; i < 4; i++) step();
    chk("no_tmo", 32'(timeout_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Grant the pending request and leave it in WAIT_DONE (ack given, no done).
  task automatic serve_to_wait();
    int n;
    n = 0;
    while (req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wd_req", 32'(req_o), 32'd1);
    chk("wd_sel", 32'(mux_sel_o), 32'd1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("wd_busy", 32'(busy_o), 32'd1);
    chk("wd_gnt", 32'(grant_o), 32'h02);
  endtask

endmodule
